// File: rtl/pixel_pack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_pack_pkg : shared constants, state encoding and byte-enable helpers  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pixel_pack_pkg;

  localparam int BYTE_W     = 8;
  localparam int PIX_BYTES  = 3;
  localparam int WORD_BYTES = 4;

  localparam logic [WORD_BYTES-1:0] BE_FULL = 4'b1111;
  localparam logic [WORD_BYTES-1:0] BE_RES3 = 4'b0111;
  localparam logic [WORD_BYTES-1:0] BE_RES2 = 4'b0011;
  localparam logic [WORD_BYTES-1:0] BE_RES1 = 4'b0001;
  localparam logic [WORD_BYTES-1:0] BE_NONE = 4'b0000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Byte enables of the zero-padded tail word for a given residue count.
  function automatic logic [WORD_BYTES-1:0] residue_be(input logic [1:0] cnt);
    case (cnt)
      2'd3:    return BE_RES3;
      2'd2:    return BE_RES2;
      2'd1:    return BE_RES1;
      default: return BE_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_pack_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_pack_out_reg : single-entry valid/ready slot holding odat/obe/oaddr  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pixel_pack_out_reg
  import pixel_pack_pkg::*;
#(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DAT_WIDTH-1:0]  load_dat,
  input  logic [WORD_BYTES-1:0] load_be,
  input  logic                  clr_addr,
  input  logic                  ordy,
  output logic [DAT_WIDTH-1:0]  odat,
  output logic [WORD_BYTES-1:0] obe,
  output logic [ADDR_WIDTH-1:0] oaddr,
  output logic                  oval
);

  logic [DAT_WIDTH-1:0]  dat_q,  dat_d;
  logic [WORD_BYTES-1:0] be_q,   be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  val_q,  val_d;

  // The address register tracks consumed words, so a word loaded on the same
  // edge as a consume picks up the incremented address.
  always_comb begin
    dat_d  = dat_q;
    be_d   = be_q;
    addr_d = addr_q;
    val_d  = val_q;
    if (val_q && ordy) begin
      val_d  = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    if (load) begin
      val_d = 1'b1;
      dat_d = load_dat;
      be_d  = load_be;
    end
    if (clr_addr) begin
      addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_q  <= '0;
      be_q   <= '0;
      addr_q <= '0;
      val_q  <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      be_q   <= be_d;
      addr_q <= addr_d;
      val_q  <= val_d;
    end
  end

  assign odat  = dat_q;
  assign obe   = be_q;
  assign oaddr = addr_q;
  assign oval  = val_q;

endmodule
`default_nettype wire

// File: rtl/pixel_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_pack : packs 24-bit pixels into contiguous 32-bit BRAM words         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pixel_pack
  import pixel_pack_pkg::*;
#(
  parameter int DAT_WIDTH  = 32,
  parameter int PIX_WIDTH  = 24,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_WIDTH-1:0]  ipix,
  input  logic                  ival,
  output logic                  irdy,
  input  logic                  iflush,
  output logic [DAT_WIDTH-1:0]  odat,
  output logic [WORD_BYTES-1:0] obe,
  output logic [ADDR_WIDTH-1:0] oaddr,
  output logic                  oval,
  input  logic                  ordy,
  output logic                  odone
);

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q,   cnt_d;
  logic [PIX_WIDTH-1:0]    res_q,   res_d;
  logic                    odone_q, odone_d;

  logic                    slot_free;
  logic                    accept;
  logic                    load;
  logic [DAT_WIDTH-1:0]    load_dat;
  logic [WORD_BYTES-1:0]   load_be;
  logic                    clr_addr;

  assign slot_free = ~oval | ordy;
  assign irdy      = slot_free & (state_q == ST_RUN);
  assign accept    = ival & irdy;

  // Residue bytes always sit right-aligned with zeroed upper bytes, so the
  // flush word is simply the residue zero-extended.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    odone_d  = 1'b0;
    load     = 1'b0;
    load_dat = '0;
    load_be  = BE_FULL;
    clr_addr = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (cnt_q)
            2'd0: begin
              res_d = ipix;
              cnt_d = 2'(PIX_BYTES);
            end
            2'd3: begin
              load     = 1'b1;
              load_dat = {ipix[BYTE_W-1:0], res_q[3*BYTE_W-1:0]};
              res_d    = {{BYTE_W{1'b0}}, ipix[3*BYTE_W-1:BYTE_W]};
              cnt_d    = 2'd2;
            end
            2'd2: begin
              load     = 1'b1;
              load_dat = {ipix[2*BYTE_W-1:0], res_q[2*BYTE_W-1:0]};
              res_d    = {{(2*BYTE_W){1'b0}}, ipix[3*BYTE_W-1:2*BYTE_W]};
              cnt_d    = 2'd1;
            end
            default: begin
              load     = 1'b1;
              load_dat = {ipix, res_q[BYTE_W-1:0]};
              res_d    = '0;
              cnt_d    = 2'd0;
            end
          endcase
        end
        if (iflush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q != 2'd0) begin
          if (slot_free) begin
            load     = 1'b1;
            load_dat = {{BYTE_W{1'b0}}, res_q};
            load_be  = residue_be(cnt_q);
            cnt_d    = 2'd0;
            res_d    = '0;
          end
        end else if (!oval) begin
          odone_d  = 1'b1;
          clr_addr = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      res_q   <= '0;
      odone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      odone_q <= odone_d;
    end
  end

  assign odone = odone_q;

  pixel_pack_out_reg #(
    .DAT_WIDTH  (DAT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_dat (load_dat),
    .load_be  (load_be),
    .clr_addr (clr_addr),
    .ordy     (ordy),
    .odat     (odat),
    .obe      (obe),
    .oaddr    (oaddr),
    .oval     (oval)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pixel_pack : byte-stream reference model and scoreboard for pixel_pack |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pixel_pack;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  be;
    logic [15:0] addr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] ipix = '0;
  logic        ival = 1'b0;
  logic        iflush = 1'b0;
  logic        ordy = 1'b0;
  logic        irdy;
  logic [31:0] odat;
  logic [3:0]  obe;
  logic [15:0] oaddr;
  logic        oval;
  logic        odone;

  always #5 clk = ~clk;

  pixel_pack #(
    .DAT_WIDTH  (32),
    .PIX_WIDTH  (24),
    .ADDR_WIDTH (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ipix   (ipix),
    .ival   (ival),
    .irdy   (irdy),
    .iflush (iflush),
    .odat   (odat),
    .obe    (obe),
    .oaddr  (oaddr),
    .oval   (oval),
    .ordy   (ordy),
    .odone  (odone)
  );

  int          total = 0;
  int          bad = 0;
  word_t       exp_q[$];
  word_t       obs_q[$];
  logic [7:0]  byte_q[$];
  logic [15:0] m_addr = '0;
  int          exp_done = 0;
  int          done_cnt = 0;
  int          done_at = 0;
  bit          flushing = 1'b0;
  logic        s_irdy;
  logic        s_oval;
  logic [31:0] s_odat;

  // Reference model: a plain byte FIFO; every 4 bytes make one word.
  function automatic void model_push(input logic [23:0] p);
    word_t w;
    for (int i = 0; i < 3; i++) byte_q.push_back(p[8*i +: 8]);
    while (byte_q.size() >= 4) begin
      w.dat = '0;
      for (int i = 0; i < 4; i++) w.dat[8*i +: 8] = byte_q.pop_front();
      w.be   = 4'hF;
      w.addr = m_addr;
      m_addr = m_addr + 16'd1;
      exp_q.push_back(w);
    end
  endfunction

  function automatic void model_flush();
    word_t w;
    int    k;
    k = byte_q.size();
    if (k > 0) begin
      w.dat = '0;
      for (int i = 0; i < k; i++) w.dat[8*i +: 8] = byte_q.pop_front();
      w.be   = 4'((1 << k) - 1);
      w.addr = m_addr;
      exp_q.push_back(w);
    end
    m_addr   = '0;
    exp_done = exp_done + 1;
  endfunction

  function automatic void tb_begin();
    exp_q.delete();
    obs_q.delete();
    exp_done = 0;
    done_cnt = 0;
    done_at  = 0;
  endfunction

  // One clock: drive on the falling edge, sample 1ns later, then wait for the rising edge.
  task automatic step(input logic v, input logic [23:0] p, input logic f, input logic r);
    word_t w;
    @(negedge clk);
    ival = v; ipix = p; iflush = f; ordy = r;
    #1;
    s_irdy = irdy; s_oval = oval; s_odat = odat;
    if (odone === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_at  = obs_q.size();
      flushing = 1'b0;
    end
    if (oval === 1'b1 && r) begin
      w.dat = odat; w.be = obe; w.addr = oaddr;
      obs_q.push_back(w);
    end
    if (v && irdy === 1'b1) model_push(p);
    if (f && !flushing) begin
      flushing = 1'b1;
      model_flush();
    end
    @(posedge clk);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_cnt < target; i++) step(1'b0, 24'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total += 5;
    if (odat !== 32'h0)  begin bad++; $display("FAIL reset_odat got=%h exp=0", odat); end
    if (obe !== 4'h0)    begin bad++; $display("FAIL reset_obe got=%h exp=0", obe); end
    if (oaddr !== 16'h0) begin bad++; $display("FAIL reset_oaddr got=%h exp=0", oaddr); end
    if (oval !== 1'b0)   begin bad++; $display("FAIL reset_oval got=%b exp=0", oval); end
    if (odone !== 1'b0)  begin bad++; $display("FAIL reset_odone got=%b exp=0", odone); end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 24'h0, 1'b0, 1'b1);
    total++;
    if (s_irdy !== 1'b1) begin bad++; $display("FAIL reset_irdy got=%b exp=1", s_irdy); end
  endtask

  task automatic test_basic();
    logic [31:0] lit [3];
    lit[0] = 32'h04030201; lit[1] = 32'h08070605; lit[2] = 32'h0C0B0A09;
    tb_begin();
    step(1'b1, 24'h030201, 1'b0, 1'b1);
    step(1'b1, 24'h060504, 1'b0, 1'b1);
    step(1'b1, 24'h090807, 1'b0, 1'b1);
    step(1'b1, 24'h0C0B0A, 1'b0, 1'b1);
    repeat (3) step(1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_q[i] !== {lit[i], 4'hF, 16'(i)}) begin
        bad++; $display("FAIL basic_lit%0d got=%h exp=%h/f/%0d", i, obs_q[i], lit[i], i);
      end
    end
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(1);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (done_cnt != exp_done) begin bad++; $display("FAIL basic_done got=%0d exp=%0d", done_cnt, exp_done); end
  endtask

  task automatic test_flush_one();
    tb_begin();
    step(1'b1, 24'hAABBCC, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    step(1'b0, 24'h0, 1'b0, 1'b1);
    total++;
    if (s_irdy !== 1'b0) begin bad++; $display("FAIL flush1_irdy got=%b exp=0", s_irdy); end
    wait_done(1);
    total += 3;
    if (obs_q[0] !== {32'h00AABBCC, 4'b0111, 16'h0}) begin bad++; $display("FAIL flush1_word got=%h exp=00aabbcc/7/0", obs_q[0]); end
    if (done_cnt != 1) begin bad++; $display("FAIL flush1_done got=%0d exp=1", done_cnt); end
    if (done_at != 1)  begin bad++; $display("FAIL flush1_done_order got=%0d exp=1", done_at); end
    for (int i = 0; i < 4; i++) step(1'b1, 24'($urandom), 1'b0, 1'b1);
    repeat (3) step(1'b0, 24'h0, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(2);
    total++;
    if (obs_q[1].addr !== 16'h0) begin bad++; $display("FAIL flush1_next_addr got=%h exp=0", obs_q[1].addr); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL flush1_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL flush1_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush_two();
    tb_begin();
    step(1'b1, 24'h030201, 1'b0, 1'b1);
    step(1'b1, 24'h060504, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(1);
    total += 3;
    if (obs_q[0] !== {32'h04030201, 4'hF, 16'h0})    begin bad++; $display("FAIL flush2_w0 got=%h exp=04030201/f/0", obs_q[0]); end
    if (obs_q[1] !== {32'h00000605, 4'b0011, 16'h1}) begin bad++; $display("FAIL flush2_w1 got=%h exp=00000605/3/1", obs_q[1]); end
    if (done_cnt != 1 || done_at != 2) begin bad++; $display("FAIL flush2_done got=%0d@%0d exp=1@2", done_cnt, done_at); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    tb_begin();
    held = '0;
    step(1'b1, 24'($urandom), 1'b0, 1'b1);
    step(1'b1, 24'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 24'($urandom), 1'b0, 1'b0);
      if (i == 0) held = s_odat;
      total += 3;
      if (s_oval !== 1'b1) begin bad++; $display("FAIL bp_oval%0d got=%b exp=1", i, s_oval); end
      if (s_irdy !== 1'b0) begin bad++; $display("FAIL bp_irdy%0d got=%b exp=0", i, s_irdy); end
      if (s_odat !== held) begin bad++; $display("FAIL bp_odat%0d got=%h exp=%h", i, s_odat, held); end
    end
    for (int i = 0; i < 8; i++) step(1'b1, 24'($urandom), 1'b0, 1'b1);
    repeat (3) step(1'b0, 24'h0, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(1);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush_same_cycle();
    tb_begin();
    step(1'b1, 24'h030201, 1'b0, 1'b1);
    step(1'b1, 24'h0C0B0A, 1'b1, 1'b1);
    wait_done(1);
    total += 3;
    if (obs_q[0] !== {32'h0A030201, 4'hF, 16'h0})    begin bad++; $display("FAIL same_w0 got=%h exp=0a030201/f/0", obs_q[0]); end
    if (obs_q[1] !== {32'h00000C0B, 4'b0011, 16'h1}) begin bad++; $display("FAIL same_w1 got=%h exp=00000c0b/3/1", obs_q[1]); end
    if (done_cnt != 1 || obs_q.size() != 2) begin bad++; $display("FAIL same_done got=%0d/%0d exp=1/2", done_cnt, obs_q.size()); end
  endtask

  task automatic test_reset_midframe();
    tb_begin();
    step(1'b1, 24'h030201, 1'b0, 1'b0);
    step(1'b1, 24'h060504, 1'b0, 1'b0);
    @(negedge clk);
    ival = 1'b0;
    #2 rst = 1'b0;
    #1;
    total += 2;
    if (oval !== 1'b0) begin bad++; $display("FAIL midrst_oval got=%b exp=0", oval); end
    if (obe !== 4'h0)  begin bad++; $display("FAIL midrst_obe got=%h exp=0", obe); end
    @(negedge clk);
    rst = 1'b1;
    byte_q.delete();
    m_addr   = '0;
    flushing = 1'b0;
    tb_begin();
    for (int i = 0; i < 4; i++) step(1'b1, 24'($urandom), 1'b0, 1'b1);
    repeat (3) step(1'b0, 24'h0, 1'b0, 1'b1);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(1);
    total++;
    if (obs_q[0].addr !== 16'h0) begin bad++; $display("FAIL midrst_addr got=%h exp=0", obs_q[0].addr); end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    tb_begin();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, 24'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    wait_done(exp_done);
    step(1'b0, 24'h0, 1'b1, 1'b1);
    wait_done(exp_done);
    total += 2;
    if (done_cnt != exp_done) begin bad++; $display("FAIL rand_done got=%0d exp=%0d", done_cnt, exp_done); end
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_one();
    test_flush_two();
    test_backpressure();
    test_flush_same_cycle();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
